// File: rtl/mste_cpu_clkgen.sv
// Mega STE CPU clock-enable generator: 8/16 MHz 68000 phase enables.
// Optional sync-wait statistics counter: define MSTE_SYNC_STATS_EN.
module mste_cpu_clkgen #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_16mhz,
    input  logic              enable_cache,
    input  logic              cpu_as_n,
    input  logic              cache_hit,
    output logic              cpu_en_p,
    output logic              cpu_en_n,
    output logic              cpu_fast,
    output logic              sync_wait,
    output logic [STAT_W-1:0] sync_cycles
);

    typedef enum logic [1:0] {
        SLOW,
        FAST,
        SYNC,
        BUS
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       req_fast_q;
    logic       en_p_q, en_p_d;
    logic       en_n_q, en_n_d;
    logic       fast_q, fast_d;
    logic       wait_q, wait_d;
    logic       slot;
    logic       miss;

    assign cnt_d = cnt_q + 2'd1;
    assign slot  = (cnt_q == 2'd3);
    assign miss  = ~cpu_as_n & ~(enable_cache & cache_hit);

    // A miss sampled at cnt 2 lands on the slot boundary: skip SYNC entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOW: begin
                if (slot & req_fast_q & cpu_as_n)
                    state_d = FAST;
            end
            FAST: begin
                if (~cnt_q[0] & miss)
                    state_d = (cnt_q == 2'd2) ? BUS : SYNC;
                else if (slot & ~req_fast_q & cpu_as_n)
                    state_d = SLOW;
            end
            SYNC: begin
                if (cnt_q == 2'd2)
                    state_d = BUS;
            end
            BUS: begin
                if (slot & cpu_as_n)
                    state_d = req_fast_q ? FAST : SLOW;
            end
            default: state_d = SLOW;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        en_p_d = 1'b0;
        en_n_d = 1'b0;
        fast_d = 1'b0;
        wait_d = 1'b0;
        unique case (state_d)
            FAST: begin
                en_p_d = cnt_d[0];
                en_n_d = ~cnt_d[0];
                fast_d = 1'b1;
            end
            SYNC: begin
                fast_d = 1'b1;
                wait_d = 1'b1;
            end
            default: begin
                en_p_d = (cnt_d == 2'd3);
                en_n_d = (cnt_d == 2'd1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SLOW;
            cnt_q      <= 2'd0;
            req_fast_q <= 1'b0;
            en_p_q     <= 1'b0;
            en_n_q     <= 1'b0;
            fast_q     <= 1'b0;
            wait_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_fast_q <= enable_16mhz;
            en_p_q     <= en_p_d;
            en_n_q     <= en_n_d;
            fast_q     <= fast_d;
            wait_q     <= wait_d;
        end
    end

    assign cpu_en_p  = en_p_q;
    assign cpu_en_n  = en_n_q;
    assign cpu_fast  = fast_q;
    assign sync_wait = wait_q;

`ifdef MSTE_SYNC_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stat_q <= '0;
        else if (wait_q && (stat_q != '1))
            stat_q <= stat_q + STAT_W'(1);
    end

    assign sync_cycles = stat_q;
`else
    assign sync_cycles = '0;
`endif

endmodule

// File: tb/tb_mste_cpu_clkgen.sv
// Randomized bench for mste_cpu_clkgen against a slot-arithmetic model.
module tb_mste_cpu_clkgen;

    localparam int STAT_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable_16mhz = 1'b0;
    logic              enable_cache = 1'b1;
    logic              cpu_as_n = 1'b1;
    logic              cache_hit = 1'b0;
    logic              cpu_en_p;
    logic              cpu_en_n;
    logic              cpu_fast;
    logic              sync_wait;
    logic [STAT_W-1:0] sync_cycles;

    int checks = 0;
    int errors = 0;

    // Model: clk index since reset, speed mode, bus hold, end of sync window.
    int t;
    bit m_fast;
    bit m_bus;
    bit m_req;
    int sync_until;
    int m_stat;
    int last_ph;
    bit rst_pend;

    always #5 clk = ~clk;

    mste_cpu_clkgen #(.STAT_W(STAT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_16mhz (enable_16mhz),
        .enable_cache (enable_cache),
        .cpu_as_n     (cpu_as_n),
        .cache_hit    (cache_hit),
        .cpu_en_p     (cpu_en_p),
        .cpu_en_n     (cpu_en_n),
        .cpu_fast     (cpu_fast),
        .sync_wait    (sync_wait),
        .sync_cycles  (sync_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at t=%0d", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_fast = 1'b0;
        m_bus = 1'b0;
        m_req = 1'b0;
        sync_until = 0;
        m_stat = 0;
        last_ph = 0;
    endtask

    task automatic drive();
        if ($urandom_range(0, 39) == 0) enable_16mhz = ~enable_16mhz;
        if ($urandom_range(0, 99) == 0) enable_cache = ~enable_cache;
        if ($urandom_range(0, 5) == 0) cpu_as_n = ~cpu_as_n;
        cache_hit = ($urandom_range(0, 2) != 0);
    endtask

    // Advance the model one clk using the inputs held during clk t.
    task automatic model_step();
        int c;
        c = t % 4;
        if (t < sync_until) begin
            // waiting for the 8 MHz slot; nothing can change speed
        end else if (m_bus) begin
            if (c == 3 && cpu_as_n) begin
                m_bus = 1'b0;
                m_fast = m_req;
            end
        end else if (m_fast) begin
            if (c % 2 == 0 && !cpu_as_n && !(enable_cache && cache_hit)) begin
                m_bus = 1'b1;
                sync_until = t + 3 - c;
            end else if (c == 3 && cpu_as_n && !m_req) begin
                m_fast = 1'b0;
            end
        end else if (c == 3 && cpu_as_n && m_req) begin
            m_fast = 1'b1;
        end
        m_req = enable_16mhz;
        t++;
    endtask

    task automatic check_cycle();
        int c;
        int per;
        bit s;
        bit ef;
        bit ep;
        bit en;
        logic [31:0] exp_stat;
        c = t % 4;
        s = (t < sync_until);
        ef = m_fast && !m_bus;
        per = ef ? 2 : 4;
        ep = !s && (c % per == per - 1);
        en = !s && (c % per == per / 2 - 1);
`ifdef MSTE_SYNC_STATS_EN
        exp_stat = m_stat;
`else
        exp_stat = 0;
`endif
        chk("en_p", cpu_en_p, ep);
        chk("en_n", cpu_en_n, en);
        chk("fast", cpu_fast, s || ef);
        chk("wait", sync_wait, s);
        chk("stat", sync_cycles, exp_stat);
        chk("excl", cpu_en_p & cpu_en_n, 0);
        if (cpu_en_p === 1'b1) begin
            chk("alt_p", last_ph == 1, 0);
            last_ph = 1;
        end
        if (cpu_en_n === 1'b1) begin
            chk("alt_n", last_ph == 2, 0);
            last_ph = 2;
        end
        if (s && m_stat < (1 << STAT_W) - 1) m_stat++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_p"}, cpu_en_p, 0);
        chk({tag, "_n"}, cpu_en_n, 0);
        chk({tag, "_fast"}, cpu_fast, 0);
        chk({tag, "_wait"}, sync_wait, 0);
        chk({tag, "_stat"}, sync_cycles, 0);
    endtask

    initial begin
        model_reset();
        rst_pend = 1'b0;
        #12;
        chk_zero("rst");
        @(negedge clk);
        drive();
        reset_n = 1'b1;
        model_step();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (i == 1200 || i == 2800) rst_pend = 1'b1;
            if (rst_pend && t < sync_until) begin
                chk("pre_rst_wait", sync_wait, 1);
                #2 reset_n = 1'b0;
                #1;
                chk_zero("midrst");
                @(negedge clk);
                model_reset();
                drive();
                reset_n = 1'b1;
                model_step();
                rst_pend = 1'b0;
                continue;
            end
            check_cycle();
            drive();
            model_step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
